// File: rtl/full_add_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_add_4_pkg
// Description : Shared width constant and carry-plus-sum result type.
// Revision    : 1.0 - initial release
// ============================================================================
package full_add_4_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic                       carry;
        logic [c_DEFAULT_WIDTH-1:0] sum;
    } result_t;

endpackage : full_add_4_pkg
`default_nettype wire

// File: rtl/full_add_4_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_add_1
// Description : One-bit full adder cell, the element of the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_add_1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign sum    = w_prop ^ c_in;
    assign c_out  = (a & b) | (c_in & w_prop);

endmodule : full_add_1
`default_nettype wire

// File: rtl/full_add_4.sv
`default_nettype none
// ============================================================================
// Module      : full_add_4
// Description : Ripple-carry adder of WIDTH full_add_1 cells, result registered.
// Revision    : 1.0 - initial release
// ============================================================================
module full_add_4
    import full_add_4_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    assign w_carry[0] = c_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_add_1 u_fa (
                .a     (a[i]),
                .b     (b[i]),
                .c_in  (w_carry[i]),
                .sum   (w_sum[i]),
                .c_out (w_carry[i+1])
            );
        end
    endgenerate

    // Reset wins over the add; it also discards whatever result was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_c_out <= w_carry[WIDTH];
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule : full_add_4
`default_nettype wire

// File: tb/tb_full_add_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_add_4
// Description : Scoreboard bench for full_add_4: directed vectors plus full sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_add_4;
    import full_add_4_pkg::*;

    typedef struct {
        result_t exp;
        string   tag;
    } sb_entry_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;

    sb_entry_t  sb_q[$];
    int         n_cmp;
    int         n_fail;

    full_add_4 #(.WIDTH(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the result is expected after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] va, input logic [3:0] vb,
                         input logic vc, input logic [4:0] exp, input string tag);
        sb_entry_t e;
        @(negedge clk);
        rst  = r;
        a    = va;
        b    = vb;
        c_in = vc;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: check each registered result, then confirm it holds through the input change.
    initial begin
        sb_entry_t e;
        logic [4:0] held;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({c_out, sum} !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got {c_out,sum}=%h required %h at %0t",
                             e.tag, {c_out, sum}, e.exp, $time);
                end
                held = {c_out, sum};
                @(negedge clk);
                #1;
                n_cmp++;
                if ({c_out, sum} !== held) begin
                    n_fail++;
                    $display("FAIL hold_%s: got {c_out,sum}=%h required %h at %0t",
                             e.tag, {c_out, sum}, held, $time);
                end
            end
        end
    end

    initial begin
        logic [8:0] cnt;
        logic [4:0] exp;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        a      = 4'hF;
        b      = 4'hF;
        c_in   = 1'b1;

        drive(1'b1, 4'hF, 4'hF, 1'b1, 5'h00, "rst_cycle0");
        drive(1'b1, 4'hF, 4'hF, 1'b1, 5'h00, "rst_cycle1");

        drive(1'b0, 4'h3, 4'h4, 1'b0, 5'h07, "add_3_4");
        drive(1'b0, 4'hF, 4'h1, 1'b0, 5'h10, "wrap_f_1");
        drive(1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, "max_f_f_1");
        drive(1'b0, 4'hA, 4'h5, 1'b1, 5'h10, "propagate_a_5");
        drive(1'b0, 4'h0, 4'h0, 1'b0, 5'h00, "zero");
        drive(1'b1, 4'h9, 4'h9, 1'b1, 5'h00, "rst_priority");
        drive(1'b0, 4'h6, 4'h9, 1'b0, 5'h0F, "after_rst_6_9");

        // Sweep all 512 combinations plus the wrap back to zero, with one reset cycle mid-stream.
        cnt = 9'd0;
        for (int i = 0; i <= 512; i++) begin
            exp = 5'(cnt[3:0]) + 5'(cnt[7:4]) + 5'(cnt[8]);
            if (i == 300)
                drive(1'b1, cnt[3:0], cnt[7:4], cnt[8], 5'h00, "sweep_rst");
            drive(1'b0, cnt[3:0], cnt[7:4], cnt[8], exp, "sweep");
            cnt = cnt + 9'd1;
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results required 0", sb_q.size());
        end
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_full_add_4
`default_nettype wire
